// File: rtl/exec_sequencer_if.sv
// Control/debug bundle between the run controller and the datapath / debug host.
// The sequencer uses the slave modport; the datapath or debug host uses master.
interface exec_sequencer_if #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 8
);
  logic              run;
  logic              step;
  logic              halt_req;
  logic [ADDR_W-1:0] pc_addr;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic              pc_en;
  logic              commit;
  logic [1:0]        phase;
  logic              halted;
  logic              bp_hit;
  logic [CNT_W-1:0]  retired_cnt;
  logic [CNT_W-1:0]  cycle_cnt;

  modport master (
    output run, step, halt_req, pc_addr, bp_en, bp_addr,
    input  pc_en, commit, phase, halted, bp_hit, retired_cnt, cycle_cnt
  );

  modport slave (
    input  run, step, halt_req, pc_addr, bp_en, bp_addr,
    output pc_en, commit, phase, halted, bp_hit, retired_cnt, cycle_cnt
  );
endinterface

// File: rtl/exec_sequencer.sv
// FETCH/EXEC/COMMIT run controller with run, step, halt, PC breakpoint and retire counter.
// Define EXEC_SEQ_CYCLE_CNT_EN to build the non-IDLE cycle counter; otherwise cycle_cnt reads 0.
module exec_sequencer #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  exec_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              single_mode, single_mode_nxt;
  logic              skip_bp, skip_bp_nxt;
  logic              halt_pend, halt_pend_nxt;
  logic              bp_hit, bp_hit_nxt;
  logic [CNT_W-1:0]  retired_cnt;
  logic [ADDR_W-1:0] pc_cur;
  logic [ADDR_W-1:0] bp_pc;
  logic              bp_match;

  assign pc_cur   = bus.pc_addr;
  assign bp_pc    = bus.bp_addr;
  // skip_bp lets the instruction we stopped on execute once after a resume
  assign bp_match = bus.bp_en && (pc_cur == bp_pc) && !skip_bp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      single_mode <= 1'b0;
      skip_bp     <= 1'b0;
      halt_pend   <= 1'b0;
      bp_hit      <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state       <= state_nxt;
      single_mode <= single_mode_nxt;
      skip_bp     <= skip_bp_nxt;
      halt_pend   <= halt_pend_nxt;
      bp_hit      <= bp_hit_nxt;
      if (state == S_COMMIT)
        retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt       = state;
    single_mode_nxt = single_mode;
    skip_bp_nxt     = skip_bp;
    halt_pend_nxt   = halt_pend;
    bp_hit_nxt      = bp_hit;
    unique case (state)
      S_IDLE: begin
        // a halt request coincident with run/step vetoes the start
        if (!bus.halt_req && (bus.run || bus.step)) begin
          state_nxt       = S_FETCH;
          single_mode_nxt = !bus.run;
          skip_bp_nxt     = 1'b1;
          bp_hit_nxt      = 1'b0;
        end
      end
      S_FETCH: begin
        if (bp_match) begin
          state_nxt     = S_IDLE;
          bp_hit_nxt    = 1'b1;
          halt_pend_nxt = 1'b0;
        end else begin
          state_nxt = S_EXEC;
          if (bus.halt_req) halt_pend_nxt = 1'b1;
        end
      end
      S_EXEC: begin
        state_nxt = S_COMMIT;
        if (bus.halt_req) halt_pend_nxt = 1'b1;
      end
      S_COMMIT: begin
        skip_bp_nxt   = 1'b0;
        halt_pend_nxt = 1'b0;
        if (single_mode || halt_pend || bus.halt_req)
          state_nxt = S_IDLE;
        else
          state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.pc_en       = (state == S_COMMIT);
  assign bus.commit      = (state == S_COMMIT);
  assign bus.phase       = state;
  assign bus.halted      = (state == S_IDLE);
  assign bus.bp_hit      = bp_hit;
  assign bus.retired_cnt = retired_cnt;

`ifdef EXEC_SEQ_CYCLE_CNT_EN
  logic [CNT_W-1:0] cycle_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cycle_cnt <= '0;
    else if (state != S_IDLE)
      cycle_cnt <= cycle_cnt + CNT_W'(1);
  end

  assign bus.cycle_cnt = cycle_cnt;
`else
  assign bus.cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: a small PC register stands in for the datapath.
module tb_exec_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pc_clr = 1'b1;
  logic [7:0] pc = 8'd0;
  int         checks = 0;
  int         errors = 0;

  exec_sequencer_if #(.CNT_W(16), .ADDR_W(8)) bus ();

  exec_sequencer #(.CNT_W(16), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // datapath PC register: advances only when the sequencer grants pc_en
  always @(posedge clk) begin
    if (pc_clr)          pc <= 8'd0;
    else if (bus.pc_en)  pc <= pc + 8'd1;
  end
  assign bus.pc_addr = pc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    pc_clr       = 1'b1;
    bus.run      = 1'b0;
    bus.step     = 1'b0;
    bus.halt_req = 1'b0;
    bus.bp_en    = 1'b0;
    bus.bp_addr  = 8'd0;
    tick();
    tick();
    reset  = 1'b1;
    pc_clr = 1'b0;
  endtask

  task automatic pulse_run();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    #1;
    if (bus.phase !== 2'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", bus.phase); end
    checks++;
    if (bus.halted !== 1'b1) begin errors++; $display("FAIL reset_halted got %0b exp 1", bus.halted); end
    checks++;
    if ({bus.pc_en, bus.commit, bus.bp_hit} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000", {bus.pc_en, bus.commit, bus.bp_hit});
    end
    checks++;
    if (bus.retired_cnt !== 16'd0 || bus.cycle_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", bus.retired_cnt, bus.cycle_cnt);
    end
    checks++;
    reset = 1'b1;
  endtask

  task automatic test_run();
    int pc_en_cnt;
    int n;
    logic [15:0] exp_cyc;
    do_reset();
    pulse_run();
    pc_en_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.phase !== 2'(1 + i % 3)) begin
        errors++; $display("FAIL run_phase cyc %0d got %0d exp %0d", i, bus.phase, 1 + i % 3);
      end
      checks++;
      if (bus.pc_en !== (i % 3 == 2)) begin
        errors++; $display("FAIL run_pc_en cyc %0d got %0b exp %0b", i, bus.pc_en, (i % 3 == 2));
      end
      checks++;
      if (bus.pc_en === 1'b1) pc_en_cnt++;
      tick();
    end
    if (bus.retired_cnt !== 16'd4) begin errors++; $display("FAIL run_retired got %0d exp 4", bus.retired_cnt); end
    checks++;
    if (pc !== 8'd4) begin errors++; $display("FAIL run_pc got %0d exp 4", pc); end
    checks++;
`ifdef EXEC_SEQ_CYCLE_CNT_EN
    exp_cyc = 16'd12;
`else
    exp_cyc = 16'd0;
`endif
    if (bus.cycle_cnt !== exp_cyc) begin errors++; $display("FAIL run_cycle_cnt got %0d exp %0d", bus.cycle_cnt, exp_cyc); end
    checks++;
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    n = 0;
    while (bus.halted !== 1'b1 && n < 10) begin tick(); n++; end
    if (bus.halted !== 1'b1 || bus.retired_cnt !== 16'd5) begin
      errors++; $display("FAIL run_stop halted %0b retired %0d exp 1/5", bus.halted, bus.retired_cnt);
    end
    checks++;
  endtask

  task automatic test_step();
    int pc_en_cnt;
    do_reset();
    pc_en_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (bus.pc_en === 1'b1) pc_en_cnt++;
        tick();
      end
      if (bus.halted !== 1'b1 || bus.phase !== 2'd0) begin
        errors++; $display("FAIL step_halted got %0b/%0d exp 1/0", bus.halted, bus.phase);
      end
      checks++;
    end
    if (bus.retired_cnt !== 16'd2) begin errors++; $display("FAIL step_retired got %0d exp 2", bus.retired_cnt); end
    checks++;
    if (pc_en_cnt !== 2) begin errors++; $display("FAIL step_pc_en_cnt got %0d exp 2", pc_en_cnt); end
    checks++;
  endtask

  task automatic test_breakpoint();
    int n;
    do_reset();
    bus.bp_en   = 1'b1;
    bus.bp_addr = 8'h05;
    pulse_run();
    n = 0;
    while (bus.halted !== 1'b1 && n < 100) begin tick(); n++; end
    if (bus.bp_hit !== 1'b1) begin errors++; $display("FAIL bp_hit1 got %0b exp 1", bus.bp_hit); end
    checks++;
    if (bus.retired_cnt !== 16'd5 || pc !== 8'h05) begin
      errors++; $display("FAIL bp_stop1 retired %0d pc %0d exp 5/5", bus.retired_cnt, pc);
    end
    checks++;
    pulse_run();
    if (bus.bp_hit !== 1'b0 || bus.phase !== 2'd1) begin
      errors++; $display("FAIL bp_resume bp_hit %0b phase %0d exp 0/1", bus.bp_hit, bus.phase);
    end
    checks++;
    tick();
    if (bus.phase !== 2'd2) begin errors++; $display("FAIL bp_skip phase got %0d exp 2", bus.phase); end
    checks++;
    n = 0;
    while (bus.halted !== 1'b1 && n < 1000) begin tick(); n++; end
    if (bus.bp_hit !== 1'b1 || pc !== 8'h05) begin
      errors++; $display("FAIL bp_hit2 bp_hit %0b pc %0d exp 1/5", bus.bp_hit, pc);
    end
    checks++;
    if (bus.retired_cnt !== 16'd261) begin errors++; $display("FAIL bp_retired2 got %0d exp 261", bus.retired_cnt); end
    checks++;
  endtask

  task automatic test_halt();
    do_reset();
    pulse_run();
    for (int i = 0; i < 7; i++) tick();
    if (bus.phase !== 2'd2) begin errors++; $display("FAIL halt_in_exec phase got %0d exp 2", bus.phase); end
    checks++;
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    if (bus.phase !== 2'd3 || bus.commit !== 1'b1) begin
      errors++; $display("FAIL halt_commit phase %0d commit %0b exp 3/1", bus.phase, bus.commit);
    end
    checks++;
    tick();
    if (bus.halted !== 1'b1 || bus.retired_cnt !== 16'd3 || pc !== 8'd3) begin
      errors++; $display("FAIL halt_idle halted %0b retired %0d pc %0d exp 1/3/3", bus.halted, bus.retired_cnt, pc);
    end
    checks++;
  endtask

  task automatic test_coincident();
    do_reset();
    bus.run      = 1'b1;
    bus.halt_req = 1'b1;
    tick();
    tick();
    if (bus.phase !== 2'd0 || bus.halted !== 1'b1) begin
      errors++; $display("FAIL run_halt_idle phase %0d halted %0b exp 0/1", bus.phase, bus.halted);
    end
    checks++;
    bus.halt_req = 1'b0;
    bus.step     = 1'b1;
    tick();
    bus.run  = 1'b0;
    bus.step = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.halted !== 1'b0) begin errors++; $display("FAIL run_step_free cyc %0d halted %0b exp 0", i, bus.halted); end
      checks++;
      tick();
    end
    if (bus.retired_cnt !== 16'd2) begin errors++; $display("FAIL run_step_retired got %0d exp 2", bus.retired_cnt); end
    checks++;
  endtask

  task automatic test_reset_in_commit();
    do_reset();
    pulse_run();
    for (int i = 0; i < 8; i++) tick();
    if (bus.phase !== 2'd3 || bus.retired_cnt !== 16'd2) begin
      errors++; $display("FAIL pre_reset phase %0d retired %0d exp 3/2", bus.phase, bus.retired_cnt);
    end
    checks++;
    reset = 1'b0;
    #1;
    if (bus.phase !== 2'd0 || bus.pc_en !== 1'b0 || bus.commit !== 1'b0 || bus.halted !== 1'b1) begin
      errors++; $display("FAIL async_reset phase %0d pc_en %0b commit %0b halted %0b exp 0/0/0/1",
                         bus.phase, bus.pc_en, bus.commit, bus.halted);
    end
    checks++;
    if (bus.retired_cnt !== 16'd0 || bus.cycle_cnt !== 16'd0) begin
      errors++; $display("FAIL async_reset_cnt got %0d/%0d exp 0/0", bus.retired_cnt, bus.cycle_cnt);
    end
    checks++;
    tick();
    if (pc !== 8'd2) begin errors++; $display("FAIL reset_pc_hold got %0d exp 2", pc); end
    checks++;
    reset = 1'b1;
  endtask

  initial begin
    bus.run      = 1'b0;
    bus.step     = 1'b0;
    bus.halt_req = 1'b0;
    bus.bp_en    = 1'b0;
    bus.bp_addr  = 8'd0;
    test_reset();
    test_run();
    test_step();
    test_breakpoint();
    test_halt();
    test_coincident();
    test_reset_in_commit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle run controller for the 8-bit single-issue datapath.
- Sequences each instruction through FETCH, EXEC and COMMIT phases.
- Drives the PC enable and a commit gate that qualifies register-file and data-memory writes.
- Provides run, halt, single-step and a PC breakpoint, plus a retired-instruction counter for debug and bring-up.

Parameters:
- CNT_W, 16, width of retired_cnt and cycle_cnt
- ADDR_W, 8, width of pc_addr and bp_addr

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  level-sampled start request; honoured only in IDLE
- step  in  1  execute exactly one instruction; honoured only in IDLE
- halt_req  in  1  stop at the next instruction boundary
- pc_addr  in  ADDR_W  current PC value from the datapath
- bp_en  in  1  breakpoint enable
- bp_addr  in  ADDR_W  breakpoint PC
- pc_en  out  1  PC advance enable; high only in COMMIT
- commit  out  1  write gate ANDed with RegWrite/MemWrite by the datapath; high only in COMMIT
- phase  out  2  0=IDLE, 1=FETCH, 2=EXEC, 3=COMMIT
- halted  out  1  high when in IDLE
- bp_hit  out  1  sticky: the last stop was caused by the breakpoint
- retired_cnt  out  CNT_W  count of committed instructions
- cycle_cnt  out  CNT_W  non-IDLE cycle count (optional feature)

Behaviour:
- Async reset (reset=0):
  - state=IDLE, phase=0, halted=1.
  - pc_en=0, commit=0, bp_hit=0.
  - retired_cnt=0, cycle_cnt=0.
  - skip_bp=0, halt_pend=0.
- pc_en, commit, phase and halted decode combinationally from the registered state. No other output depends combinationally on inputs.
- IDLE:
  - run=1 -> FETCH, single_mode=0.
  - else step=1 -> FETCH, single_mode=1.
  - Either exit sets skip_bp=1 and clears bp_hit.
  - run and step together: run wins.
  - halt_req=1 in the same cycle as run/step: stay in IDLE, no state change.
- FETCH:
  - If bp_en=1, pc_addr==bp_addr and skip_bp=0: -> IDLE, bp_hit=1, no commit, PC unchanged.
  - Otherwise -> EXEC.
- EXEC -> COMMIT unconditionally.
- COMMIT:
  - pc_en=commit=1 for exactly one cycle.
  - At the closing edge: retired_cnt+=1, wrapping modulo 2^CNT_W; skip_bp cleared.
  - Next state is IDLE if single_mode=1, or if halt_pend=1, or if halt_req=1 this cycle. Otherwise FETCH.
  - halt_pend is cleared on entering IDLE.
- halt_req outside IDLE (FETCH/EXEC/COMMIT): sets halt_pend. The instruction in flight always completes.
- halt_req in IDLE: ignored, unless coincident with run/step (see IDLE).
- Breakpoint vs halt in the same FETCH: breakpoint wins; bp_hit=1, halt_pend cleared.
- Latency:
  - run sampled at edge t -> FETCH at t+1, COMMIT at t+3, next FETCH at t+4.
  - Steady state is 3 cycles per instruction.
- Resume from a breakpoint: skip_bp guarantees the breakpointed instruction executes once before the breakpoint re-arms.
- Reset asserted mid-instruction: immediate IDLE. The commit of the in-flight instruction is dropped, with no partial PC or register-file write.

Optional Feature:
- Macro EXEC_SEQ_CYCLE_CNT_EN.
- Defined: cycle_cnt increments on every clock edge where state!=IDLE, wrapping modulo 2^CNT_W. It is reset to 0 only by reset; it is not cleared by run/step.
- Undefined: cycle_cnt is tied to 0 and no counter flops are inferred. Port list is identical in both builds.

Test Plan:
- Reset then 1-cycle run pulse -> phase sequence 1,2,3,1,2,3...; pc_en high exactly every 3rd cycle; retired_cnt=4 after 12 cycles from FETCH entry.
- Two step pulses from IDLE, separated by 5 idle cycles -> two single COMMITs; halted=1 between them; retired_cnt=2; pc_en high exactly 2 cycles total.
- bp_en=1, bp_addr=0x05, run from pc 0 -> stop in FETCH at pc_addr=0x05; bp_hit=1; retired_cnt=5. Second run -> 0x05 executes, bp_hit clears; next stop requires PC to return to 0x05.
- halt_req pulse during EXEC of instruction 3 -> that instruction commits; IDLE after COMMIT; retired_cnt=3.
- run and halt_req asserted together in IDLE -> stays IDLE, phase=0. run and step together -> free-running mode, no return to IDLE after the first COMMIT.
- reset driven low during COMMIT -> all outputs at reset values immediately (asynchronous); retired_cnt=0; cycle_cnt=0 in both macro builds.
